fifo_array_drain: RTL

- Consumer end of the output FIFO array that collects per-column results of the systolic array.
- Drains the array_size column FIFOs in strict row-major, column-round-robin order.
- Writes each word to the output feature-map memory through a single write port with an auto-incrementing address.
- Sits between the output FIFO array and the output BRAM. It is started once per output tile by the layer controller.

---
 rtl/fifo_array_drain.sv | 107 ++++++++++
 1 files changed

// File: rtl/fifo_array_drain.sv
// rtl/fifo_array_drain.sv - drains the column FIFO array row-major into the output memory
// Each word takes a CHECK (issue r_en) and a CAPT (register FIFO data) cycle.
module fifo_array_drain #(
  parameter int data_size  = 16,
  parameter int array_size = 9,
  parameter int addr_width = 16,
  parameter int row_width  = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [row_width-1:0]           num_rows,
  input  logic [addr_width-1:0]          base_addr,
  input  logic [array_size-1:0]          empty,
  input  logic [data_size*array_size-1:0] out_bus,
  output logic [array_size-1:0]          r_en,
  output logic                           mem_wr_en,
  output logic [addr_width-1:0]          mem_addr,
  output logic [data_size-1:0]           mem_data,
  output logic                           busy,
  output logic                           done
);

  localparam int col_width = (array_size > 1) ? $clog2(array_size) : 1;
  localparam logic [col_width-1:0] last_col = col_width'(array_size - 1);

  typedef enum logic [1:0] {IDLE, CHECK, CAPT, FIN} state_t;

  state_t                state;
  state_t                state_next;
  logic [row_width-1:0]  rows;
  logic [row_width-1:0]  row;
  logic [col_width-1:0]  col;
  logic [addr_width-1:0] addr;
  logic                  last_word;

  assign last_word = (col == last_col) && (row == rows - row_width'(1));
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    r_en       = '0;
    case (state)
      IDLE: begin
        if (start) state_next = (num_rows == '0) ? FIN : CHECK;
      end
      CHECK: begin
        // Stall on the current column; never skip ahead to a ready one.
        if (!empty[col]) begin
          r_en[col]  = 1'b1;
          state_next = CAPT;
        end
      end
      CAPT: begin
        state_next = last_word ? FIN : CHECK;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows      <= '0;
      row       <= '0;
      col       <= '0;
      addr      <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_wr_en <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rows <= num_rows;
            row  <= '0;
            col  <= '0;
            addr <= base_addr;
          end
        end
        CAPT: begin
          mem_data  <= out_bus[col*data_size +: data_size];
          mem_addr  <= addr;
          mem_wr_en <= 1'b1;
          addr      <= addr + addr_width'(1);
          if (col == last_col) begin
            col <= '0;
            row <= row + row_width'(1);
          end else begin
            col <= col + col_width'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
